// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
//   XLEN         : architectural register / PC width
//   run_cmd_e    : debug run-control command opcodes (3 bits, 5-7 illegal)
//   halt_cause_e : reason the core was last halted (2 bits)
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        CMD_RUN   = 3'd0,
        CMD_HALT  = 3'd1,
        CMD_STEP  = 3'd2,
        CMD_SETBP = 3'd3,
        CMD_CLRBP = 3'd4
    } run_cmd_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_CMD  = 2'd1,
        CAUSE_BP   = 2'd2,
        CAUSE_STEP = 2'd3
    } halt_cause_e;

endpackage

// File: rtl/core_run_ctrl.sv
// Run/halt/step controller sitting between the debug host and the core.
// The core retires an instruction only in cycles where run_o is high.
//
// Ports:
//   clk_i, rst_i      : clock (rising edge), asynchronous active-high reset
//   cmd_valid_i       : command present; cmd_ready_o is tied high
//   cmd_op_i          : run_cmd_e opcode
//   cmd_data_i        : SETBP address or STEP count (low STEP_W bits)
//   update_i, pc_i    : core retire strobe and PC of the retiring instruction
//   run_o             : registered retire enable (high in RUNNING/STEPPING)
//   halted_o          : controller is HALTED
//   halt_cause_o      : halt_cause_e of the most recent halt
//   retire_cnt_o      : instructions retired while run_o was high
//   last_pc_o         : PC of the most recent counted retirement
//   err_o             : one-cycle pulse on protocol or command error
module core_run_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int STEP_W    = 16,
    parameter int RET_W     = 32,
    parameter bit START_RUN = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [XLEN-1:0]   cmd_data_i,
    input  logic              update_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic              run_o,
    output logic              halted_o,
    output logic [1:0]        halt_cause_o,
    output logic [RET_W-1:0]  retire_cnt_o,
    output logic [XLEN-1:0]   last_pc_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } run_state_e;

    localparam run_state_e RESET_STATE = START_RUN ? ST_RUNNING : ST_HALTED;

    run_state_e          state_q, state_n;
    halt_cause_e         cause_q, cause_n;
    logic [STEP_W-1:0]   step_left, step_n;
    logic [STEP_W-1:0]   step_cnt;
    logic                bp_en;
    logic [XLEN-1:0]     bp_addr;
    logic                err_n;
    logic                counted;
    logic                bp_hit;
    logic                last_step;

    assign cmd_ready_o  = 1'b1;
    assign halted_o     = (state_q == ST_HALTED);
    assign halt_cause_o = cause_q;

    // A retire only counts when the core was actually enabled this cycle.
    assign counted   = update_i & run_o;
    // Breakpoint registers are compared before any same-cycle SETBP/CLRBP lands.
    assign bp_hit    = counted & bp_en & (pc_i == bp_addr);
    assign last_step = counted & (state_q == ST_STEPPING) & (step_left == STEP_W'(1));
    assign step_cnt  = cmd_data_i[STEP_W-1:0];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n = state_q;
        cause_n = cause_q;
        step_n  = step_left;
        err_n   = 1'b0;

        if (update_i && !run_o) begin
            err_n = 1'b1;
        end
        if (cmd_valid_i && (cmd_op_i > 3'd4)) begin
            err_n = 1'b1;
        end
        if (counted && (state_q == ST_STEPPING)) begin
            step_n = step_left - STEP_W'(1);
        end

        // Halting events outrank commands; RUN/STEP alongside one are dropped quietly.
        if (bp_hit) begin
            state_n = ST_HALTED;
            cause_n = CAUSE_BP;
            step_n  = '0;
        end else if (last_step) begin
            state_n = ST_HALTED;
            cause_n = CAUSE_STEP;
            step_n  = '0;
        end else if (cmd_valid_i) begin
            case (cmd_op_i)
                CMD_RUN: begin
                    if (state_q != ST_RUNNING) begin
                        state_n = ST_RUNNING;
                        step_n  = '0;
                    end
                end
                CMD_HALT: begin
                    if (state_q != ST_HALTED) begin
                        state_n = ST_HALTED;
                        cause_n = CAUSE_CMD;
                        step_n  = '0;
                    end
                end
                CMD_STEP: begin
                    if (state_q == ST_HALTED) begin
                        state_n = ST_STEPPING;
                        step_n  = (step_cnt == '0) ? STEP_W'(1) : step_cnt;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: ;  // SETBP/CLRBP handled below; illegal flagged above
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RESET_STATE;
            run_o        <= START_RUN;
            cause_q      <= CAUSE_NONE;
            step_left    <= '0;
            bp_en        <= 1'b0;
            bp_addr      <= '0;
            retire_cnt_o <= '0;
            last_pc_o    <= '0;
            err_o        <= 1'b0;
        end else begin
            state_q   <= state_n;
            run_o     <= (state_n != ST_HALTED);
            cause_q   <= cause_n;
            step_left <= step_n;
            err_o     <= err_n;

            if (counted) begin
                retire_cnt_o <= retire_cnt_o + RET_W'(1);
                last_pc_o    <= pc_i;
            end

            if (cmd_valid_i && (cmd_op_i == CMD_SETBP)) begin
                bp_addr <= cmd_data_i;
                bp_en   <= 1'b1;
            end else if (cmd_valid_i && (cmd_op_i == CMD_CLRBP)) begin
                bp_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl (START_RUN = 0, XLEN = 32).
// Directed vector table, hand-written corner sequences, then random stimulus
// compared against a behavioural model built on a run flag plus step budget.
module tb_core_run_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i;
    logic [31:0] cmd_data_i;
    logic        update_i;
    logic [31:0] pc_i;
    logic        run_o;
    logic        halted_o;
    logic [1:0]  halt_cause_o;
    logic [31:0] retire_cnt_o;
    logic [31:0] last_pc_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    core_run_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_data_i   (cmd_data_i),
        .update_i     (update_i),
        .pc_i         (pc_i),
        .run_o        (run_o),
        .halted_o     (halted_o),
        .halt_cause_o (halt_cause_o),
        .retire_cnt_o (retire_cnt_o),
        .last_pc_o    (last_pc_o),
        .err_o        (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] data;
        logic        upd;
        logic [31:0] pc;
        logic        e_run;
        logic        e_halt;
        logic [1:0]  e_cause;
        logic [31:0] e_cnt;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_run, input logic e_halt,
                           input logic [1:0] e_cause, input logic [31:0] e_cnt,
                           input logic [31:0] e_pc, input logic e_err);
        check({tag, ".run"},    64'(run_o),        64'(e_run));
        check({tag, ".halted"}, 64'(halted_o),     64'(e_halt));
        check({tag, ".cause"},  64'(halt_cause_o), 64'(e_cause));
        check({tag, ".cnt"},    64'(retire_cnt_o), 64'(e_cnt));
        check({tag, ".lastpc"}, 64'(last_pc_o),    64'(e_pc));
        check({tag, ".err"},    64'(err_o),        64'(e_err));
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] data,
                       input logic upd, input logic [31:0] pc);
        cmd_valid_i = v;
        cmd_op_i    = op;
        cmd_data_i  = data;
        update_i    = upd;
        pc_i        = pc;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        update_i    = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic add(input logic v, input logic [2:0] op, input logic [31:0] data,
                       input logic upd, input logic [31:0] pc, input logic e_run,
                       input logic e_halt, input logic [1:0] e_cause,
                       input logic [31:0] e_cnt, input logic [31:0] e_pc, input logic e_err);
        vec_t r;
        r.v = v; r.op = op; r.data = data; r.upd = upd; r.pc = pc;
        r.e_run = e_run; r.e_halt = e_halt; r.e_cause = e_cause;
        r.e_cnt = e_cnt; r.e_pc = e_pc; r.e_err = e_err;
        vecs.push_back(r);
    endtask

    // ---------------- behavioural reference model ----------------
    // m_run: core enabled. m_budget: -1 free-running, otherwise retires left in a step.
    bit          m_run;
    int          m_budget;
    logic [1:0]  m_cause;
    bit          m_bp_en;
    logic [31:0] m_bp;
    logic [31:0] m_cnt;
    logic [31:0] m_lpc;
    bit          m_err;

    task automatic model_reset();
        m_run = 0; m_budget = -1; m_cause = 2'd0; m_bp_en = 0; m_bp = '0;
        m_cnt = '0; m_lpc = '0; m_err = 0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] op, input logic [31:0] data,
                              input logic upd, input logic [31:0] pc);
        bit counted;
        bit halted_now;
        counted    = upd && m_run;
        halted_now = 0;
        m_err      = (upd && !m_run) || (v && op > 3'd4);
        if (counted) begin
            m_cnt = m_cnt + 1;
            m_lpc = pc;
        end
        if (counted && m_bp_en && pc == m_bp) begin
            m_run = 0; m_cause = 2'd2; halted_now = 1;
        end else if (counted && m_budget == 1) begin
            m_run = 0; m_cause = 2'd3; halted_now = 1;
        end else if (counted && m_budget > 1) begin
            m_budget = m_budget - 1;
        end
        if (!halted_now && v) begin
            case (op)
                3'd0: begin m_run = 1; m_budget = -1; end
                3'd1: if (m_run) begin m_run = 0; m_cause = 2'd1; end
                3'd2: begin
                    if (m_run) m_err = 1;
                    else begin
                        m_run    = 1;
                        m_budget = (data[15:0] == 16'd0) ? 1 : int'(data[15:0]);
                    end
                end
                default: ;
            endcase
        end
        if (v && op == 3'd3) begin m_bp = data; m_bp_en = 1; end
        if (v && op == 3'd4) m_bp_en = 0;
    endtask

    initial begin
        rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_data_i = '0;
        update_i = 1'b0; pc_i = '0;

        // Directed table: inputs for one cycle, expected outputs after that edge.
        //   v  op    data          upd pc        run halt cause cnt pc     err
        add(0, 3'd0, 32'h0,        0, 32'h0,     0, 1, 2'd0, 0,  32'h0,   0);
        add(1, 3'd0, 32'h0,        0, 32'h0,     1, 0, 2'd0, 0,  32'h0,   0);
        add(0, 3'd0, 32'h0,        1, 32'h0,     1, 0, 2'd0, 1,  32'h0,   0);
        add(0, 3'd0, 32'h0,        1, 32'h4,     1, 0, 2'd0, 2,  32'h4,   0);
        add(0, 3'd0, 32'h0,        1, 32'h8,     1, 0, 2'd0, 3,  32'h8,   0);
        add(1, 3'd1, 32'h0,        0, 32'h0,     0, 1, 2'd1, 3,  32'h8,   0);
        add(1, 3'd2, 32'h3,        0, 32'h0,     1, 0, 2'd1, 3,  32'h8,   0);
        add(0, 3'd0, 32'h0,        1, 32'h10,    1, 0, 2'd1, 4,  32'h10,  0);
        add(0, 3'd0, 32'h0,        1, 32'h14,    1, 0, 2'd1, 5,  32'h14,  0);
        add(0, 3'd0, 32'h0,        1, 32'h18,    0, 1, 2'd3, 6,  32'h18,  0);
        add(0, 3'd0, 32'h0,        1, 32'h1c,    0, 1, 2'd3, 6,  32'h18,  1);
        add(0, 3'd0, 32'h0,        1, 32'h20,    0, 1, 2'd3, 6,  32'h18,  1);
        add(1, 3'd3, 32'h100,      0, 32'h0,     0, 1, 2'd3, 6,  32'h18,  0);
        add(1, 3'd0, 32'h0,        0, 32'h0,     1, 0, 2'd3, 6,  32'h18,  0);
        add(0, 3'd0, 32'h0,        1, 32'hf8,    1, 0, 2'd3, 7,  32'hf8,  0);
        add(0, 3'd0, 32'h0,        1, 32'hfc,    1, 0, 2'd3, 8,  32'hfc,  0);
        add(0, 3'd0, 32'h0,        1, 32'h100,   0, 1, 2'd2, 9,  32'h100, 0);
        add(0, 3'd0, 32'h0,        1, 32'h104,   0, 1, 2'd2, 9,  32'h100, 1);
        add(1, 3'd6, 32'h0,        0, 32'h0,     0, 1, 2'd2, 9,  32'h100, 1);
        add(0, 3'd0, 32'h0,        0, 32'h0,     0, 1, 2'd2, 9,  32'h100, 0);
        add(1, 3'd4, 32'h0,        0, 32'h0,     0, 1, 2'd2, 9,  32'h100, 0);
        add(1, 3'd2, 32'hffff0000, 0, 32'h0,     1, 0, 2'd2, 9,  32'h100, 0);
        add(0, 3'd0, 32'h0,        1, 32'h100,   0, 1, 2'd3, 10, 32'h100, 0);
        add(1, 3'd0, 32'h0,        0, 32'h0,     1, 0, 2'd3, 10, 32'h100, 0);
        add(1, 3'd2, 32'h5,        0, 32'h0,     1, 0, 2'd3, 10, 32'h100, 1);
        add(1, 3'd1, 32'h0,        0, 32'h0,     0, 1, 2'd1, 10, 32'h100, 0);

        do_reset();
        check("ready", 64'(cmd_ready_o), 64'd1);
        foreach (vecs[i]) begin
            cyc(vecs[i].v, vecs[i].op, vecs[i].data, vecs[i].upd, vecs[i].pc);
            chk_all($sformatf("vec%0d", i), vecs[i].e_run, vecs[i].e_halt,
                    vecs[i].e_cause, vecs[i].e_cnt, vecs[i].e_pc, vecs[i].e_err);
        end

        // Breakpoint on the last step plus HALT in the same cycle: BP wins.
        cyc(1, 3'd3, 32'h100, 0, 32'h0);
        cyc(1, 3'd2, 32'h2,   0, 32'h0);
        cyc(0, 3'd0, 32'h0,   1, 32'h50);
        cyc(1, 3'd1, 32'h0,   1, 32'h100);
        chk_all("bp_step_halt", 0, 1, 2'd2, 12, 32'h100, 0);

        // Last step plus HALT in the same cycle: STEP wins.
        cyc(1, 3'd2, 32'h2,   0, 32'h0);
        cyc(0, 3'd0, 32'h0,   1, 32'h60);
        cyc(1, 3'd1, 32'h0,   1, 32'h64);
        chk_all("step_halt", 0, 1, 2'd3, 14, 32'h64, 0);

        // STEP command alongside a breakpoint hit is dropped with no error.
        cyc(1, 3'd0, 32'h0,   0, 32'h0);
        cyc(1, 3'd2, 32'h4,   1, 32'h100);
        chk_all("bp_drop_step", 0, 1, 2'd2, 15, 32'h100, 0);

        // RUN while stepping discards the remaining budget.
        cyc(1, 3'd2, 32'h5,   0, 32'h0);
        cyc(0, 3'd0, 32'h0,   1, 32'h70);
        cyc(1, 3'd0, 32'h0,   0, 32'h0);
        for (int k = 0; k < 5; k++) cyc(0, 3'd0, 32'h0, 1, 32'h74 + 32'(4 * k));
        chk_all("run_from_step", 1, 0, 2'd2, 21, 32'h84, 0);
        cyc(1, 3'd1, 32'h0,   0, 32'h0);
        chk_all("halt_after_run", 0, 1, 2'd1, 21, 32'h84, 0);

        // Asynchronous reset in the middle of a step sequence.
        do_reset();
        cyc(1, 3'd3, 32'h200,      0, 32'h0);
        cyc(1, 3'd2, 32'habcd000c, 0, 32'h0);
        for (int k = 0; k < 7; k++) cyc(0, 3'd0, 32'h0, 1, 32'h10 + 32'(4 * k));
        chk_all("pre_reset", 1, 0, 2'd0, 7, 32'h28, 0);
        rst_i = 1'b1;
        #1;
        chk_all("async_reset", 0, 1, 2'd0, 0, 32'h0, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc(1, 3'd2, 32'h1,   0, 32'h0);
        cyc(0, 3'd0, 32'h0,   1, 32'h200);
        chk_all("step1_after_reset", 0, 1, 2'd3, 1, 32'h200, 0);
        cyc(0, 3'd0, 32'h0,   1, 32'h200);
        chk_all("halted_retire", 0, 1, 2'd3, 1, 32'h200, 1);

        // Random stimulus against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        v;
            logic [2:0]  op;
            logic [31:0] data;
            logic        upd;
            logic [31:0] pc;
            int          r;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                model_reset();
            end
            v  = ($urandom_range(0, 2) == 0);
            r  = int'($urandom_range(0, 15));
            op = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 10) ? 3'd2 :
                 (r < 12) ? 3'd3 : (r < 14) ? 3'd4 : 3'(5 + $urandom_range(0, 2));
            pc = 32'h100 + 32'(4 * $urandom_range(0, 3));
            if (op == 3'd2) data = {16'($urandom), 16'($urandom_range(0, 5))};
            else            data = 32'h100 + 32'(4 * $urandom_range(0, 3));
            upd = ($urandom_range(0, 9) < 7);
            cyc(v, op, data, upd, pc);
            model_step(v, op, data, upd, pc);
            chk_all($sformatf("rnd%0d", n), m_run, !m_run, m_cause, m_cnt, m_lpc, m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run/halt/step controller that sequences core_model for debug and bring-up. Accepts commands over a valid/ready port, gates instruction retirement through run_o, and watches the core's retire strobe and PC. Halts on command, on a PC breakpoint, or when a step budget is exhausted. Sits between the test/debug host and the core; the core retires an instruction only in cycles where run_o is high.

Parameters:
XLEN, riscv_pkg::XLEN, width of PC, breakpoint address and command data
STEP_W, 16, width of the step counter; bits [STEP_W-1:0] of cmd_data_i are used
RET_W, 32, width of the retired-instruction counter
START_RUN, 0, 1 = leave reset in RUNNING, 0 = leave reset in HALTED

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready; tied high
cmd_op_i  in  3  run_cmd_e: RUN=0, HALT=1, STEP=2, SETBP=3, CLRBP=4; 5-7 illegal
cmd_data_i  in  XLEN  SETBP address, or STEP count
update_i  in  1  core retires an instruction at the end of this cycle
pc_i  in  XLEN  PC of the instruction retiring this cycle
run_o  out  1  core retire enable, registered
halted_o  out  1  state == HALTED
halt_cause_o  out  2  halt_cause_e: NONE=0, CMD=1, BP=2, STEP=3
retire_cnt_o  out  RET_W  instructions retired while run_o was high
last_pc_o  out  XLEN  pc_i of the most recent counted retirement
err_o  out  1  one-cycle pulse on protocol or command error

Behaviour:
- Reset values: state = RUNNING if START_RUN else HALTED; run_o = START_RUN; halt_cause_o = NONE; bp_en = 0; bp_addr = 0; step_left = 0; retire_cnt_o = 0; last_pc_o = 0; err_o = 0.
- Reset is honoured at any point, including mid-step; no pending state survives it.
- States: HALTED, RUNNING, STEPPING. run_o = 1 exactly when state is RUNNING or STEPPING. Every state change takes effect at the next edge, so run_o follows one cycle later.
- Counted retire: update_i & run_o. Each counted retire increments retire_cnt_o (wraps modulo 2^RET_W) and loads pc_i into last_pc_o.
- update_i while run_o is low: not counted, err_o pulses.
- Breakpoint hit: counted retire & bp_en & pc_i == bp_addr. The hitting instruction completes and is counted; next state is HALTED with cause BP.
- HALTED:
  - RUN -> RUNNING.
  - STEP -> STEPPING with step_left = count; a count of 0 is treated as 1.
  - HALT -> no-op.
  - Entering RUNNING or STEPPING leaves halt_cause_o unchanged until the next halt.
- RUNNING:
  - HALT -> HALTED, cause CMD.
  - RUN -> no-op.
  - STEP -> err_o pulses, ignored.
- STEPPING:
  - Each counted retire decrements step_left.
  - Counted retire with step_left == 1 -> HALTED, cause STEP.
  - HALT -> HALTED, cause CMD.
  - RUN -> RUNNING, remaining steps discarded.
  - STEP -> err_o pulses, ignored.
- SETBP: bp_addr = cmd_data_i and bp_en = 1, in any state. CLRBP: bp_en = 0. A breakpoint changed in the same cycle as a retire applies from the next cycle; the compare uses the old values.
- Illegal opcode: err_o pulses, no effect.
- Simultaneous events in one cycle, priority:
  - Breakpoint hit beats the last step, which beats a HALT command.
  - The winning event sets the cause.
  - A RUN or STEP command in the same cycle as a halting event is dropped silently; no err_o.
- A single-instruction loop sitting on the breakpoint halts after every retire. This is intended.

Decomposition:
- riscv_pkg gains run_cmd_e (3 bits) and halt_cause_e (2 bits).
- XLEN comes from riscv_pkg.
- No sub-module. The FSM, step counter, breakpoint compare and retire counter are one flat module.

Test Plan:
- Reset with START_RUN=0, then RUN at cycle 2, then update_i each cycle with pc 0x0,0x4,0x8 -> run_o rises at cycle 3; retire_cnt_o = 3; last_pc_o = 0x8; halted_o = 0.
- From HALTED, STEP with data 3, then 5 retires offered -> exactly 3 counted; next cycle halted_o = 1, cause STEP, run_o = 0; further update_i pulses err_o and retire_cnt_o stays 3.
- SETBP 0x100, RUN, retire pcs 0xF8,0xFC,0x100,0x104 -> halts after 0x100; last_pc_o = 0x100; cause BP; count 3; the 0x104 retire pulses err_o.
- STEP data 2 where the 2nd retire is pc 0x100 with bp 0x100, plus HALT in the same cycle -> cause BP.
- STEP data 0 -> exactly one retire, then cause STEP. Opcode 6 -> err_o pulses one cycle, state unchanged.
- Assert rst_i mid-STEPPING with step_left = 5 and retire_cnt = 7 -> immediately run_o = 0, halted_o = 1, cause NONE, count 0, bp_en cleared; the next STEP 1 retires exactly one.
